// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: sequential PC generation, in-order imem requests,
// and a small response FIFO feeding the IF/ID register, with redirect flush.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pcq_q [DEPTH];
  logic [31:0]   pcq_d [DEPTH];
  logic [PW-1:0] pcq_head_q, pcq_head_d;
  logic [PW-1:0] pcq_tail_q, pcq_tail_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [CW:0]   occupancy;
  logic [CW-1:0] out_after_rsp;
  logic          pop;
  logic          push;
  logic          accept;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pcq_d         = pcq_q;
    pcq_head_d    = pcq_head_q;
    pcq_tail_d    = pcq_tail_q;
    drop_d        = drop_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_cnt_d    = fifo_cnt_q;
    push          = 1'b0;

    occupancy      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    fetch_valid    = (fifo_cnt_q != '0);
    pop            = fetch_valid && !stall && !redirect_valid;
    imem_req_valid = !reset && !redirect_valid &&
                     ((occupancy < DEPTH_OCC) || ((occupancy == DEPTH_OCC) && pop));
    imem_addr      = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;

    pc_out          = fetch_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    instruction_out = fetch_valid ? fifo_instr_q[fifo_rd_q] : NOP_INSTR;

    // Every response retires the oldest in-flight PC, whether kept or dropped.
    out_after_rsp = outstanding_q - CW'(imem_rsp_valid);
    outstanding_d = out_after_rsp + CW'(accept);
    if (imem_rsp_valid) pcq_head_d = ptr_inc(pcq_head_q);

    if (accept) begin
      pcq_d[pcq_tail_q] = fetch_pc_q;
      pcq_tail_d        = ptr_inc(pcq_tail_q);
      fetch_pc_d        = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = out_after_rsp;
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
    end else begin
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push                    = 1'b1;
          fifo_pc_d[fifo_wr_q]    = pcq_q[pcq_head_q];
          fifo_instr_d[fifo_wr_q] = imem_rsp_data;
          fifo_wr_d               = ptr_inc(fifo_wr_q);
        end
      end
      if (pop) fifo_rd_d = ptr_inc(fifo_rd_q);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      pcq_q         <= '{default: '0};
      pcq_head_q    <= '0;
      pcq_tail_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_pc_q     <= '{default: '0};
      fifo_instr_q  <= '{default: '0};
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pcq_q         <= pcq_d;
      pcq_head_q    <= pcq_head_d;
      pcq_tail_q    <= pcq_tail_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage. It generates the sequential PC, issues in-order requests to instruction memory over a ready/valid handshake, and buffers returned words in a DEPTH-entry response FIFO. It presents one {pc, instruction} pair per cycle to the IF/ID pipeline register, which sits directly downstream. Branch/jump redirects flush all in-flight and buffered fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, max fetches in flight plus buffered (response FIFO depth)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address
- imem_rsp_valid  in  1  one-cycle pulse per accepted request, in order
- imem_rsp_data  in  32  instruction word
- stall  in  1  downstream not accepting (inverse of IF/ID write)
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  redirect target
- fetch_valid  out  1  pc_out/instruction_out hold a live fetch
- pc_out  out  32  PC of head entry
- instruction_out  out  32  instruction of head entry

## Operation
- State: fetch_pc (32b), in-flight PC queue (DEPTH entries), outstanding count, drop count, response FIFO (DEPTH × {pc, instr}).
- occupancy = outstanding + FIFO count; invariant occupancy ≤ DEPTH; FIFO never overflows.
- pop = fetch_valid && !stall && !redirect_valid.
- imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH || (occupancy == DEPTH && pop)).
- imem_addr = fetch_pc. On accept (req_valid && req_ready): push fetch_pc to PC queue, outstanding++, fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0).
- Response when drop count > 0: discard, drop--, outstanding--, pop PC queue.
- Response when drop count == 0: push {PC queue head, rsp_data} to FIFO, outstanding--.
- fetch_valid = FIFO non-empty. pc_out/instruction_out = FIFO head. When empty: pc_out = 0, instruction_out = 32'h0000_0013 (NOP).
- Redirect (highest priority, overrides stall):
  - FIFO flushed.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - drop count ← outstanding after this cycle's response, if any. A response arriving in the redirect cycle is discarded directly.
  - No request is issued in the redirect cycle.
- Redirect and stall together: redirect wins, no pop.
- Reset: fetch_pc = RESET_PC, counts 0, queues empty. Instruction memory shares reset, so no responses arrive for pre-reset requests.

## Timing
- Reset values: imem_req_valid 0, imem_addr RESET_PC, fetch_valid 0, pc_out 0, instruction_out 32'h13.
- First request in the first cycle with reset low.
- Request accepted at T, response at T+k (k ≥ 1): entry visible on fetch_valid at T+k+1. Min latency 2 cycles.
- With k = 1, ready held high, no stall: sustained throughput is 1 instruction/cycle at DEPTH = 2.
- stall holds the head stable. Responses still fill the FIFO until occupancy == DEPTH, then requests stop.
- Redirect at cycle R: fetch_valid 0 at R+1, request to the target at R+1, target instruction valid no earlier than R+3.
- Comb paths: stall/redirect_valid → imem_req_valid only.

## Test plan
- Reset, ready = 1, 1-cycle memory returning addr-based words: fetch_valid rises cycle 3. pc_out sequence 0, 4, 8, 12 on consecutive cycles; instruction_out matches.
- stall high 5 cycles mid-stream: pc_out frozen at 0x10, imem_req_valid drops once occupancy = 2. After release, pc resumes at 0x14 with no gap or duplicate.
- Redirect to 0x200 while 2 fetches are outstanding and memory latency is 3: both stale responses dropped. Next fetch_valid shows pc 0x200; 0x204 follows.
- Redirect same cycle as a response and stall: response discarded, no request that cycle, no stale pc ever output.
- imem_req_ready random 50%, latency random 1–4: output pc stream strictly +4 and data correct. Occupancy never exceeds 2.
- redirect_pc = 0xFFFF_FFFE: fetch at 0xFFFF_FFFC, then wraps to 0x0000_0000. Reset asserted mid-stream: next cycle fetch_valid 0, and the first request after reset goes to RESET_PC.
